// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA pixel-tick divider, h/v counters, registered syncs and blanked colour.
// Optional blink output enabled by defining VGA_SYNC_BLINK_EN.
module vga_sync_gen #(
  parameter int TICK_DIV  = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] rgb_in,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       video_on,
  output logic       p_tick,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb_out,
  output logic       frame_start,
  output logic       blink
);
  localparam int DW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [9:0] H_DISP = 10'(H_DISPLAY);
  localparam logic [9:0] V_DISP = 10'(V_DISPLAY);
  localparam logic [9:0] H_LAST = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] HS_BEG = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  logic [DW-1:0] div_cnt;
  logic [9:0] h_count, v_count;
  logic h_wrap;
  assign pix_x       = h_count;
  assign pix_y       = v_count;
  assign h_wrap      = h_count == H_LAST;
  assign video_on    = h_count < H_DISP && v_count < V_DISP;
  // reset gates the tick so it also wins over a pending tick mid-frame
  assign p_tick      = div_cnt == DIV_LAST && !reset;
  assign frame_start = p_tick && h_wrap && v_count == V_LAST;
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      h_count <= '0;
      v_count <= '0;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      rgb_out <= 3'b000;
    end else begin
      div_cnt <= p_tick ? '0 : div_cnt + 1'b1;
      if (p_tick) begin
        h_count <= h_wrap ? 10'd0 : h_count + 10'd1;
        if (h_wrap) v_count <= v_count == V_LAST ? 10'd0 : v_count + 10'd1;
        hsync   <= !(h_count >= HS_BEG && h_count <= HS_END);
        vsync   <= !(v_count >= VS_BEG && v_count <= VS_END);
        rgb_out <= video_on ? rgb_in : 3'b000;
      end
    end
  end
`ifdef VGA_SYNC_BLINK_EN
  logic [4:0] frame_cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
      blink     <= 1'b0;
    end else if (frame_start) begin
      frame_cnt <= frame_cnt + 5'd1;
      if (&frame_cnt) blink <= ~blink;
    end
  end
`else
  assign blink = 1'b0;
`endif
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: vector table plus scoreboard checks of vga_sync_gen on a reduced timing.
module tb_vga_sync_gen;
  localparam int TD = 3;
  localparam int HD = 10, HF = 2, HS = 3, HB = 2;
  localparam int VD = 6, VF = 1, VS = 2, VB = 2;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FT = HT * VT;
`ifdef VGA_SYNC_BLINK_EN
  localparam int BL_EN = 1;
`else
  localparam int BL_EN = 0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic [2:0] rgb_in = 3'b000;
  logic [9:0] pix_x, pix_y;
  logic video_on, p_tick, hsync, vsync, frame_start, blink;
  logic [2:0] rgb_out;
  always #5 clk = ~clk;
  vga_sync_gen #(
    .TICK_DIV(TD), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .reset(reset), .rgb_in(rgb_in), .pix_x(pix_x), .pix_y(pix_y),
    .video_on(video_on), .p_tick(p_tick), .hsync(hsync), .vsync(vsync),
    .rgb_out(rgb_out), .frame_start(frame_start), .blink(blink)
  );
  typedef struct {int h; int v; int hs; int vs; int rgb;} exp_t;
  typedef struct {logic rst; logic [2:0] rgb; int p; int px; int py; int hs; int vs; int ro;} vec_t;
  exp_t sb[$];
  vec_t tbl[9];
  int n_vec = 0, n_err = 0;
  int md, mh, mv, mhs, mvs, mro, mfc, mbl;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask
  task automatic step(input logic r, input logic [2:0] c);
    exp_t e;
    int tick;
    reset = r;
    rgb_in = c;
    @(posedge clk);
    if (r) begin
      md = 0; mh = 0; mv = 0; mhs = 1; mvs = 1; mro = 0; mfc = 0; mbl = 0;
      sb.delete();
    end else begin
      tick = int'(md == TD - 1);
      md = tick != 0 ? 0 : md + 1;
      if (tick != 0) begin
        mhs = int'(!(mh >= HD + HF && mh < HD + HF + HS));
        mvs = int'(!(mv >= VD + VF && mv < VD + VF + VS));
        mro = (mh < HD && mv < VD) ? int'(c) : 0;
        if (mh == HT - 1 && mv == VT - 1) begin
          if (BL_EN != 0 && mfc == 31) mbl = 1 - mbl;
          mfc = (mfc + 1) % 32;
        end
        mv = (mh == HT - 1) ? (mv == VT - 1 ? 0 : mv + 1) : mv;
        mh = mh == HT - 1 ? 0 : mh + 1;
        e = '{mh, mv, mhs, mvs, mro};
        sb.push_back(e);
      end
    end
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("pix_x", 32'(pix_x), e.h);
      chk("pix_y", 32'(pix_y), e.v);
      chk("hsync", 32'(hsync), e.hs);
      chk("vsync", 32'(vsync), e.vs);
      chk("rgb_out", 32'(rgb_out), e.rgb);
    end
    chk("p_tick", 32'(p_tick), 32'(md == TD - 1 && !r));
    chk("frame_start", 32'(frame_start), 32'(md == TD - 1 && !r && mh == HT - 1 && mv == VT - 1));
    chk("video_on", 32'(video_on), 32'(mh < HD && mv < VD));
    chk("blink", 32'(blink), mbl);
  endtask
  // counts p_ticks up to and including the next frame_start; cnt=-1 when the bound expires
  task automatic run_frame(output int cnt, output int hl, output int vl);
    int ok = 0;
    cnt = 0; hl = 0; vl = 0;
    for (int i = 0; i < 2 * FT * TD && ok == 0; i++) begin
      step(1'b0, 3'($urandom_range(0, 7)));
      if (p_tick) begin
        cnt++;
        if (!hsync) hl++;
        if (!vsync) vl++;
      end
      ok = int'(frame_start);
    end
    if (ok == 0) cnt = -1;
  endtask
  initial begin
    int cnt, hl, vl, ok, n;
    tbl[0] = '{1'b1, 3'd7, 0, 0, 0, 1, 1, 0};
    tbl[1] = '{1'b1, 3'd7, 0, 0, 0, 1, 1, 0};
    tbl[2] = '{1'b1, 3'd7, 0, 0, 0, 1, 1, 0};
    tbl[3] = '{1'b0, 3'd7, 0, 0, 0, 1, 1, 0};
    tbl[4] = '{1'b0, 3'd7, 1, 0, 0, 1, 1, 0};
    tbl[5] = '{1'b0, 3'd5, 0, 1, 0, 1, 1, 5};
    tbl[6] = '{1'b0, 3'd3, 0, 1, 0, 1, 1, 5};
    tbl[7] = '{1'b0, 3'd3, 1, 1, 0, 1, 1, 5};
    tbl[8] = '{1'b0, 3'd2, 0, 2, 0, 1, 1, 2};
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].rst, tbl[i].rgb);
      chk("tbl_p_tick", 32'(p_tick), tbl[i].p);
      chk("tbl_pix_x", 32'(pix_x), tbl[i].px);
      chk("tbl_pix_y", 32'(pix_y), tbl[i].py);
      chk("tbl_hsync", 32'(hsync), tbl[i].hs);
      chk("tbl_vsync", 32'(vsync), tbl[i].vs);
      chk("tbl_rgb_out", 32'(rgb_out), tbl[i].ro);
    end
    run_frame(cnt, hl, vl);
    chk("first_frame_found", 32'(cnt > 0), 1);
    run_frame(cnt, hl, vl);
    chk("frame_ticks", cnt, FT);
    chk("hsync_low_ticks", hl, HS * VT);
    chk("vsync_low_ticks", vl, VS * HT);
    ok = 0;
    for (int i = 0; i < 2 * FT * TD && ok == 0; i++) begin
      step(1'b0, 3'($urandom_range(0, 7)));
      ok = int'(pix_x == 10'd5 && pix_y == 10'd3);
    end
    chk("reach_mid_frame", ok, 1);
    step(1'b1, 3'd7);
    chk("midrst_pix_x", 32'(pix_x), 0);
    chk("midrst_pix_y", 32'(pix_y), 0);
    chk("midrst_hsync", 32'(hsync), 1);
    chk("midrst_vsync", 32'(vsync), 1);
    chk("midrst_rgb_out", 32'(rgb_out), 0);
    chk("midrst_frame_start", 32'(frame_start), 0);
    run_frame(cnt, hl, vl);
    chk("midrst_next_frame", cnt, FT);
    step(1'b1, 3'd0);
    n = 0;
    for (int i = 0; i < 65 * FT * TD && n < 64; i++) begin
      step(1'b0, 3'($urandom_range(0, 7)));
      if (frame_start) begin
        n++;
        step(1'b0, 3'd0);
        if (n == 31) chk("blink_31", 32'(blink), 0);
        if (n == 32) chk("blink_32", 32'(blink), BL_EN);
        if (n == 64) chk("blink_64", 32'(blink), 0);
      end
    end
    chk("blink_frames", n, 64);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
